trig_arbiter: RTL and testbench

TRIG_ARBITER -- requirements
Module: trig_arbiter

---
 rtl/trig_pkg.sv | 8 +
 rtl/trig_arbiter_rr_picker.sv | 23 ++
 rtl/trig_arbiter.sv | 89 ++++++++
 tb/tb_trig_arbiter.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/trig_pkg.sv
// trig_pkg: shared FSM state type, function-select codes and default widths for trig_arbiter.
package trig_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, RESP} trig_state_e;
  localparam logic TRIG_SINE = 1'b0;
  localparam logic TRIG_COSINE = 1'b1;
  localparam int TRIG_ANGLE_W = 9;
  localparam int TRIG_AMP_W = 32;
endpackage

// File: rtl/trig_arbiter_rr_picker.sv
// rr_picker: picks the first set request at or after the pointer, wrapping past N-1 to 0.
module rr_picker #(
  parameter int N = 12,
  parameter int IW = 4
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_grant,
  output logic [IW-1:0] o_idx,
  output logic          o_any
);
  // Scan farthest offset first so the nearest hit from the pointer overwrites the rest.
  always_comb begin
    o_idx = '0;
    o_any = 1'b0;
    for (int k = N - 1; k >= 0; k--)
      if (i_req[(int'(i_ptr) + k) % N]) begin
        o_idx = IW'((int'(i_ptr) + k) % N);
        o_any = 1'b1;
      end
  end
  assign o_grant = o_any ? N'(1) << o_idx : '0;
endmodule

// File: rtl/trig_arbiter.sv
// trig_arbiter: round-robin front end sharing one sine/cosine core among N_REQ requesters.
// Define TRIG_ARB_TIMEOUT_EN to add a BUSY watchdog that answers with rsp_err after TIMEOUT_CYCLES.
module trig_arbiter
  import trig_pkg::*;
#(
  parameter int N_REQ = 12,
  parameter int ANGLE_W = TRIG_ANGLE_W,
  parameter int AMP_W = TRIG_AMP_W,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                          clk_100mhz,
  input  logic                          rst_n_in,
  input  logic [N_REQ-1:0]              req_valid,
  input  logic [N_REQ-1:0]              req_func,
  input  logic [N_REQ-1:0][ANGLE_W-1:0] req_angle,
  output logic [N_REQ-1:0]              req_ready,
  output logic [N_REQ-1:0]              rsp_valid,
  output logic [AMP_W-1:0]              rsp_data,
  output logic                          rsp_err,
  output logic                          core_start,
  output logic                          core_func,
  output logic [ANGLE_W-1:0]            core_value,
  input  logic [AMP_W-1:0]              core_amp,
  input  logic                          core_done
);
  localparam int IW = N_REQ > 1 ? $clog2(N_REQ) : 1;
  trig_state_e r_state, w_next;
  logic [IW-1:0] r_ptr, r_id, w_idx;
  logic [N_REQ-1:0] w_grant;
  logic w_any, w_timeout, w_done;
  logic r_func;
  logic [ANGLE_W-1:0] r_angle;
  logic [AMP_W-1:0] r_data;
  rr_picker #(.N(N_REQ), .IW(IW)) u_pick (
    .i_req(req_valid),
    .i_ptr(r_ptr),
    .o_grant(w_grant),
    .o_idx(w_idx),
    .o_any(w_any)
  );
`ifdef TRIG_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] r_cnt;
  logic r_err;
  // Counter reads 0 in the first BUSY cycle, so the watchdog fires in BUSY cycle TIMEOUT_CYCLES+1.
  assign w_timeout = r_state == BUSY && r_cnt == CW'(TIMEOUT_CYCLES);
  always_ff @(posedge clk_100mhz or negedge rst_n_in)
    if (!rst_n_in) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      r_cnt <= r_state == BUSY ? r_cnt + 1'b1 : '0;
      if (w_done) r_err <= !core_done;
    end
  assign rsp_err = r_state == RESP && r_err;
`else
  assign w_timeout = 1'b0;
  assign rsp_err = 1'b0;
`endif
  assign w_done = r_state == BUSY && (core_done || w_timeout);
  always_comb
    w_next = r_state == IDLE ? (w_any ? BUSY : IDLE) :
             r_state == BUSY ? (w_done ? RESP : BUSY) : IDLE;
  always_ff @(posedge clk_100mhz or negedge rst_n_in)
    if (!rst_n_in) begin
      r_state <= IDLE;
      r_ptr <= '0;
      r_id <= '0;
      r_func <= 1'b0;
      r_angle <= '0;
      r_data <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && w_any) begin
        r_id <= w_idx;
        r_func <= req_func[w_idx];
        r_angle <= req_angle[w_idx];
      end
      if (w_done) r_data <= core_done ? core_amp : '0;
      if (r_state == RESP) r_ptr <= r_id == IW'(N_REQ - 1) ? '0 : r_id + 1'b1;
    end
  // Grant is combinational from req_valid, so it is masked while reset is asserted.
  assign req_ready = (rst_n_in && r_state == IDLE) ? w_grant : '0;
  assign rsp_valid = r_state == RESP ? N_REQ'(1) << r_id : '0;
  assign core_start = r_state == BUSY;
  assign core_func = r_func;
  assign core_value = r_angle;
  assign rsp_data = r_data;
endmodule

// File: tb/tb_trig_arbiter.sv
// tb_trig_arbiter: directed scenarios for trig_arbiter with a per-cycle behavioural model check.
`timescale 1ns/1ps
module tb_trig_arbiter;
  localparam int N = 12;
  localparam int AW = 9;
  localparam int DW = 32;
  localparam int TO = 16;
`ifdef TRIG_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [N-1:0] req_valid = '0;
  logic [N-1:0] req_func = '0;
  logic [N-1:0][AW-1:0] req_angle = '0;
  logic [N-1:0] req_ready, rsp_valid;
  logic [DW-1:0] rsp_data;
  logic [DW-1:0] core_amp = '0;
  logic rsp_err, core_start, core_func;
  logic core_done = 1'b0;
  logic [AW-1:0] core_value;
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  trig_arbiter #(.N_REQ(N), .ANGLE_W(AW), .AMP_W(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk_100mhz(clk),
    .rst_n_in(rst_n),
    .req_valid(req_valid),
    .req_func(req_func),
    .req_angle(req_angle),
    .req_ready(req_ready),
    .rsp_valid(rsp_valid),
    .rsp_data(rsp_data),
    .rsp_err(rsp_err),
    .core_start(core_start),
    .core_func(core_func),
    .core_value(core_value),
    .core_amp(core_amp),
    .core_done(core_done)
  );

  typedef struct {int id; int cyc; logic [DW-1:0] data; logic err;} ev_t;
  ev_t gq[$];
  ev_t rq[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  function automatic int oh2i(input logic [N-1:0] v);
    for (int k = 0; k < N; k++) if (v[k]) return k;
    return -1;
  endfunction

  // Model: phase 0 waits for requests, 1 waits on the core, 2 answers; m_age counts cycles since accept.
  int m_phase = 0;
  int m_id = 0;
  int m_ptr = 0;
  int m_age = 0;
  logic [DW-1:0] m_data = '0;
  logic m_err = 1'b0;
  logic m_func = 1'b0;
  logic [AW-1:0] m_angle = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0; m_ptr = 0; m_id = 0; m_data = '0; m_err = 1'b0; m_func = 1'b0; m_angle = '0;
    end else if (m_phase == 0) begin
      if (pick(req_valid, m_ptr) >= 0) begin
        m_id = pick(req_valid, m_ptr);
        m_phase = 1; m_age = 1; m_func = req_func[m_id]; m_angle = req_angle[m_id];
      end
    end else if (m_phase == 1) begin
      if (core_done) begin m_phase = 2; m_data = core_amp; m_err = 1'b0; end
      else if (TO_EN && m_age == TO + 1) begin m_phase = 2; m_data = '0; m_err = 1'b1; end
      else m_age++;
    end else begin
      m_phase = 0; m_ptr = (m_id + 1) % N;
    end
  end

  always @(negedge clk) begin
    logic [N-1:0] e_ready, e_valid;
    int g;
    ev_t e;
    g = pick(req_valid, m_ptr);
    e_ready = (rst_n && m_phase == 0 && g >= 0) ? N'(1) << g : '0;
    e_valid = m_phase == 2 ? N'(1) << m_id : '0;
    chk("req_ready", 64'(req_ready), 64'(e_ready));
    chk("rsp_valid", 64'(rsp_valid), 64'(e_valid));
    chk("core_start", 64'(core_start), 64'(m_phase == 1));
    chk("rsp_data", 64'(rsp_data), 64'(m_data));
    chk("rsp_err", 64'(rsp_err), 64'(m_phase == 2 && m_err));
    chk("core_func", 64'(core_func), 64'(m_func));
    chk("core_value", 64'(core_value), 64'(m_angle));
    if (req_ready != '0) begin
      e.id = oh2i(req_ready); e.cyc = cyc; e.data = '0; e.err = 1'b0;
      gq.push_back(e);
    end
    if (rsp_valid != '0) begin
      e.id = oh2i(rsp_valid); e.cyc = cyc; e.data = rsp_data; e.err = rsp_err;
      rq.push_back(e);
    end
  end

  // Core stand-in: raises core_done in the (core_lat+1)-th cycle of core_start; spur_req fires one stray pulse.
  bit core_auto = 1'b0;
  int core_lat = 0;
  logic [DW-1:0] core_val = '0;
  int spur_req = 0;
  initial begin : core_emu
    int n, seen;
    n = 0; seen = 0;
    forever begin
      @(negedge clk);
      if (spur_req != seen) begin
        seen = spur_req; core_done = 1'b1; core_amp = core_val;
      end else if (core_auto) begin
        n = core_start ? n + 1 : 0;
        core_done = core_start && n == core_lat + 1;
        if (core_done) core_amp = core_val;
      end else begin
        n = 0; core_done = 1'b0;
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_q(input string name, input bit rsp, input int n, input int budget);
    int b = 0;
    while ((rsp ? rq.size() : gq.size()) < n && b < budget) begin tick(); b++; end
    chk(name, 64'((rsp ? rq.size() : gq.size()) >= n), 64'(1));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
    gq.delete(); rq.delete();
  endtask

  initial begin
    int c0;
    tick(3);
    chk("reset_core_start", 64'(core_start), 64'(0));
    chk("reset_rsp_data", 64'(rsp_data), 64'(0));
    chk("reset_rsp_valid", 64'(rsp_valid), 64'(0));
    rst_n = 1'b1;
    tick(2);
    // Single cosine request on 3, core answers five cycles after start.
    gq.delete(); rq.delete();
    core_auto = 1'b1; core_lat = 5; core_val = 32'h0000_1234;
    req_func[3] = 1'b1; req_angle[3] = 9'd90; req_valid[3] = 1'b1;
    wait_q("t1_grant_wait", 1'b0, 1, 5);
    req_valid = '0;
    wait_q("t1_rsp_wait", 1'b1, 1, 20);
    chk("t1_acc_id", 64'(gq[0].id), 64'(3));
    chk("t1_rsp_id", 64'(rq[0].id), 64'(3));
    chk("t1_latency", 64'(rq[0].cyc - gq[0].cyc), 64'(7));
    chk("t1_data", 64'(rq[0].data), 64'h1234);
    // All twelve held valid from pointer 0.
    do_reset();
    core_lat = 2; core_val = 32'hA5A5_0F0F;
    for (int i = 0; i < N; i++) begin
      req_angle[i] = AW'(i * 37 + 5);
      req_func[i] = i[0];
    end
    req_valid = '1;
    wait_q("t2_grant_wait", 1'b0, 13, 120);
    req_valid = '0;
    wait_q("t2_rsp_wait", 1'b1, 13, 20);
    for (int i = 0; i < 13; i++) begin
      chk("t2_grant_order", 64'(gq[i].id), 64'(i % N));
      chk("t2_rsp_order", 64'(rq[i].id), 64'(i % N));
    end
    // Pointer at 11 with requests on 11 and 0.
    do_reset();
    core_lat = 1; core_val = 32'h0000_0BEE;
    req_valid[10] = 1'b1;
    wait_q("t3_setup_grant", 1'b0, 1, 5);
    req_valid = '0;
    wait_q("t3_setup_rsp", 1'b1, 1, 20);
    req_valid[11] = 1'b1; req_valid[0] = 1'b1;
    wait_q("t3_grant_wait", 1'b0, 3, 30);
    req_valid = '0;
    wait_q("t3_rsp_wait", 1'b1, 3, 20);
    chk("t3_first", 64'(gq[1].id), 64'(11));
    chk("t3_wrap", 64'(gq[2].id), 64'(0));
    // Reset pulse while the core is busy, then a late core_done.
    gq.delete(); rq.delete();
    core_lat = 20; core_val = 32'hDEAD_BEEF;
    req_valid[5] = 1'b1;
    wait_q("t4_grant_wait", 1'b0, 1, 5);
    req_valid = '0;
    tick(3);
    #2 rst_n = 1'b0;
    req_valid = '1;
    #1;
    chk("t4_async_core_start", 64'(core_start), 64'(0));
    chk("t4_async_req_ready", 64'(req_ready), 64'(0));
    chk("t4_async_rsp_valid", 64'(rsp_valid), 64'(0));
    req_valid = '0;
    #2 rst_n = 1'b1;
    tick();
    core_auto = 1'b0;
    spur_req++;
    tick(5);
    chk("t4_no_rsp", 64'(rq.size()), 64'(0));
    // Stray core_done in IDLE, then a request must still be taken at once.
    gq.delete(); rq.delete();
    spur_req++;
    tick(3);
    chk("t5_no_rsp", 64'(rq.size()), 64'(0));
    core_auto = 1'b1; core_lat = 3; core_val = 32'h0000_7777;
    req_func[2] = 1'b0; req_angle[2] = 9'd300; req_valid[2] = 1'b1;
    c0 = cyc;
    wait_q("t5_grant_wait", 1'b0, 1, 5);
    req_valid = '0;
    chk("t5_grant_cycle", 64'(gq[0].cyc), 64'(c0));
    wait_q("t5_rsp_wait", 1'b1, 1, 20);
    chk("t5_data", 64'(rq[0].data), 64'h7777);
    chk("t5_err", 64'(rq[0].err), 64'(0));
`ifdef TRIG_ARB_TIMEOUT_EN
    // Core never answers: watchdog response.
    gq.delete(); rq.delete();
    core_auto = 1'b0;
    req_valid[7] = 1'b1;
    wait_q("t6_grant_wait", 1'b0, 1, 5);
    req_valid = '0;
    wait_q("t6_rsp_wait", 1'b1, 1, 40);
    chk("t6_id", 64'(rq[0].id), 64'(7));
    chk("t6_latency", 64'(rq[0].cyc - gq[0].cyc), 64'(18));
    chk("t6_err", 64'(rq[0].err), 64'(1));
    chk("t6_data", 64'(rq[0].data), 64'(0));
`endif
    tick(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end
endmodule
